inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- RV32 instruction fetch stage, directly upstream of the instruction decoder.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers one returned instruction and presents it, with its PC, to the decoder under valid/ready.
- Accepts a redirect (branch/jump target) from execute, which squashes in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- NOP_INST, 32'h0000_0013, value driven on inst when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word address of the request; bits [1:0] are always 0.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  32  instruction word, valid only when imem_ack=1.
- inst_valid  output  1  inst and inst_pc hold a valid instruction for the decoder.
- inst_ready  input  1  decoder accepts inst this cycle.
- inst  output  32  instruction word to the decoder.
- inst_pc  output  32  PC of inst.
- inst_misalign  output  1  misaligned-target fault marker (see Optional Feature).
- redirect  input  1  load a new PC; squash all in-flight and buffered work.
- redirect_pc  input  32  new PC target.

Behaviour:
- Registers: pc, req_addr, inst buffer, inst_pc, state ∈ {IDLE, FETCH, VALID, DRAIN}.
- Reset (async, while rst=1):
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC.
  - imem_req=0, inst_valid=0, inst=NOP_INST, inst_pc=0, inst_misalign=0.
- IDLE: next edge → FETCH with req_addr=pc.
- FETCH:
  - imem_req=1, imem_addr=req_addr.
  - imem_addr is stable while imem_req=1 until ack.
  - On imem_ack (no redirect): inst=imem_rdata, inst_pc=req_addr, pc=req_addr+4, state→VALID.
- VALID:
  - inst_valid=1, imem_req=0.
  - On inst_ready: state→FETCH, req_addr=pc; inst_valid drops next cycle.
  - Without inst_ready: hold all outputs unchanged.
- DRAIN:
  - imem_req=1 with the old req_addr until imem_ack.
  - Data returned on that ack is discarded; then state→FETCH with req_addr=pc.
- Throughput: one instruction per 2 cycles with zero-wait memory. An ack in the first FETCH cycle gives inst_valid on the next cycle.
- Redirect has highest priority and may be asserted in any state:
  - Always: pc=redirect_pc with [1:0] forced to 00, inst_valid→0 next cycle, buffered inst dropped, inst reset to NOP_INST.
  - In FETCH without imem_ack: state→DRAIN.
  - In FETCH with imem_ack the same cycle: data discarded, state→FETCH at redirect_pc.
  - In IDLE or VALID: state→FETCH at redirect_pc.
  - In VALID with inst_ready also high: the decoder's accept is ignored and redirect wins.
  - In DRAIN: pc updated; draining continues.
- PC increment wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Reset asserted mid-request: imem_req drops immediately (asynchronously). The memory is also reset, so no response is expected.

Optional Feature:
- Macro: INST_FETCH_MISALIGN_TRAP_EN.
- Defined, when redirect_pc[1:0]≠00:
  - No memory request is issued.
  - Next cycle: inst_valid=1, inst=NOP_INST, inst_pc=redirect_pc (unmasked), inst_misalign=1.
  - Held until inst_ready. After that the block parks in IDLE with imem_req=0 until the next redirect.
- Undefined: bits [1:0] are silently masked and inst_misalign is tied to 0.

Decomposition:
- Shared package rv32_pkg: NOP_INST constant, RESET_PC default, XLEN=32, fetch state encoding.
- Single module; no sub-module is warranted (PC+4 is inline).

Test Plan:
- Zero-wait imem (ack in first req cycle), inst_ready=1, memory words 0x00500093, 0x00A00113 → inst_pc 0x0 then 0x4 with matching inst, one instruction per 2 cycles, imem_addr 0x0, 0x4, 0x8.
- imem_ack delayed 3 cycles → imem_req and imem_addr=0x4 stable all 3 cycles; inst_valid rises the cycle after ack.
- inst_ready held 0 for 5 cycles in VALID → inst, inst_pc and inst_valid unchanged, imem_req=0; the next fetch starts after ready.
- Redirect to 0x100 while a req to 0x8 is outstanding, ack 2 cycles later with 0xDEADBEEF → 0xDEADBEEF never appears on inst; next imem_addr=0x100; inst_pc=0x100.
- rst asserted mid-FETCH → imem_req and inst_valid go 0 asynchronously; after release the first imem_addr is RESET_PC.
- Macro defined, redirect_pc=0x102 → inst_valid=1, inst_misalign=1, inst_pc=0x102, no imem_req. Macro undefined → fetch proceeds at 0x100.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: instruction/PC defaults and the fetch-stage state encoding.
package rv32_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/inst_fetch.sv
// RV32 fetch stage: PC, single-request imem handshake, one-entry instruction buffer to decode.
// Latency: ack in first request cycle -> inst_valid next cycle (1 instr / 2 cycles at zero wait).
// Backpressure: holds inst/inst_pc until inst_ready; no new request while buffered. Macro: INST_FETCH_MISALIGN_TRAP_EN.
module inst_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_misalign,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, req_addr, inst_q, inst_pc_q;
  logic [XLEN-1:0] tgt;
  logic            load_req;
  logic            trap;
  logic            park;

  assign tgt = redirect_pc & ~32'h3;

`ifdef INST_FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap = redirect && (redirect_pc[1:0] != 2'b00);
  // misalign_q outlives the trap presentation so IDLE stays parked until a redirect
  assign park = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           misalign_q <= 1'b0;
    else if (redirect) misalign_q <= trap;
  end
`else
  assign trap = 1'b0;
  assign park = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!park) state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ack) state_nxt = ST_VALID;
      ST_VALID: if (inst_ready) state_nxt = park ? ST_IDLE : ST_FETCH;
      ST_DRAIN: if (imem_ack) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
    // An outstanding request must still be acked before the new target can be requested
    if (redirect) begin
      if (trap)
        state_nxt = ST_VALID;
      else if ((state == ST_FETCH || state == ST_DRAIN) && !imem_ack)
        state_nxt = ST_DRAIN;
      else
        state_nxt = ST_FETCH;
    end
  end

  always_comb begin
    imem_req   = (state == ST_FETCH) || (state == ST_DRAIN);
    imem_addr  = req_addr;
    inst_valid = (state == ST_VALID);
    inst       = inst_q;
    inst_pc    = inst_pc_q;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    inst_misalign = misalign_q && (state == ST_VALID);
`else
    inst_misalign = 1'b0;
`endif
  end

  assign load_req = (state_nxt == ST_FETCH) && ((state != ST_FETCH) || redirect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      inst_q    <= NOP_INST;
      inst_pc_q <= '0;
    end else begin
      if (load_req)
        req_addr <= redirect ? tgt : pc;

      if (redirect) begin
        pc     <= tgt;
        inst_q <= NOP_INST;
        if (trap) inst_pc_q <= redirect_pc;
      end else if (state == ST_FETCH && imem_ack) begin
        pc        <= req_addr + 32'd4;
        inst_q    <= imem_rdata;
        inst_pc_q <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: handshake timing, backpressure, redirect/drain, async reset, PC wrap.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_misalign;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_misalign(inst_misalign), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("rst_req",      {31'b0, imem_req},      32'd0);
    chk("rst_valid",    {31'b0, inst_valid},    32'd0);
    chk("rst_inst",     inst,                   NOP);
    chk("rst_inst_pc",  inst_pc,                32'h0);
    chk("rst_misalign", {31'b0, inst_misalign}, 32'd0);
    rst = 1'b0;

    // zero-wait memory, decoder always ready
    inst_ready = 1'b1;
    step();
    chk("z_req0",  {31'b0, imem_req}, 32'd1);
    chk("z_addr0", imem_addr,         32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_ack = 1'b0;
    chk("z_valid0", {31'b0, inst_valid}, 32'd1);
    chk("z_noreq0", {31'b0, imem_req},   32'd0);
    chk("z_inst0",  inst,                32'h0050_0093);
    chk("z_pc0",    inst_pc,             32'h0);
    step();
    chk("z_valid_drop", {31'b0, inst_valid}, 32'd0);
    chk("z_addr1",      imem_addr,           32'h4);
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
    step();
    imem_ack = 1'b0;
    chk("z_inst1", inst,    32'h00A0_0113);
    chk("z_pc1",   inst_pc, 32'h4);
    step();
    chk("z_addr2", imem_addr, 32'h8);

    // ack held off for 3 cycles: request must stay stable
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w_req",  {31'b0, imem_req},   32'd1);
      chk("w_addr", imem_addr,           32'h8);
      chk("w_nval", {31'b0, inst_valid}, 32'd0);
      if (i < 2) step();
    end
    imem_ack = 1'b1; imem_rdata = 32'h0010_0193;
    step();
    imem_ack = 1'b0;
    chk("w_valid", {31'b0, inst_valid}, 32'd1);
    chk("w_inst",  inst,                32'h0010_0193);
    chk("w_pc",    inst_pc,             32'h8);

    // decoder stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_inst",  inst,                32'h0010_0193);
      chk("bp_pc",    inst_pc,             32'h8);
      chk("bp_noreq", {31'b0, imem_req},   32'd0);
    end
    inst_ready = 1'b1;
    step();
    chk("bp_req",  {31'b0, imem_req}, 32'd1);
    chk("bp_addr", imem_addr,         32'hC);

    // redirect while the request to 0xC is outstanding
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("dr_valid", {31'b0, inst_valid}, 32'd0);
    chk("dr_req",   {31'b0, imem_req},   32'd1);
    chk("dr_addr",  imem_addr,           32'hC);
    chk("dr_inst",  inst,                NOP);
    step();
    chk("dr_addr2", imem_addr, 32'hC);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("dr_squash_valid", {31'b0, inst_valid}, 32'd0);
    chk("dr_squash_inst",  inst,                NOP);
    chk("dr_new_addr",     imem_addr,           32'h100);
    chk("dr_new_req",      {31'b0, imem_req},   32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0513;
    step();
    imem_ack = 1'b0;
    chk("dr_inst_new", inst,    32'h0000_0513);
    chk("dr_pc_new",   inst_pc, 32'h100);
    step();
    chk("dr_next_addr", imem_addr, 32'h104);

    // asynchronous reset mid-request
    #2 rst = 1'b1;
    #1;
    chk("ar_req",   {31'b0, imem_req},   32'd0);
    chk("ar_valid", {31'b0, inst_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("ar_req2",  {31'b0, imem_req}, 32'd1);
    chk("ar_addr2", imem_addr,         32'h0);

    // misaligned redirect coinciding with an ack
    redirect = 1'b1; redirect_pc = 32'h102;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    redirect = 1'b0; imem_ack = 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    chk("ma_valid",    {31'b0, inst_valid},    32'd1);
    chk("ma_flag",     {31'b0, inst_misalign}, 32'd1);
    chk("ma_pc",       inst_pc,                32'h102);
    chk("ma_inst",     inst,                   NOP);
    chk("ma_noreq",    {31'b0, imem_req},      32'd0);
    step();
    step();
    chk("ma_park_req", {31'b0, imem_req},      32'd0);
    chk("ma_park_val", {31'b0, inst_valid},    32'd0);
`else
    chk("ma_req",   {31'b0, imem_req},      32'd1);
    chk("ma_addr",  imem_addr,              32'h100);
    chk("ma_flag",  {31'b0, inst_misalign}, 32'd0);
    chk("ma_inst",  inst,                   NOP);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk("ma_inst2", inst,    32'h1234_5678);
    chk("ma_pc2",   inst_pc, 32'h100);
`endif

    // redirect beats a simultaneous decoder accept, then PC wraps past 0xFFFF_FFFC
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr_valid", {31'b0, inst_valid}, 32'd0);
    chk("wr_inst",  inst,                NOP);
    chk("wr_addr",  imem_addr,           32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    step();
    imem_ack = 1'b0;
    chk("wr_pc",   inst_pc, 32'hFFFF_FFFC);
    chk("wr_inst2", inst,   32'h0000_0073);
    step();
    chk("wr_wrap_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
